// File: rtl/memory_stage_if.sv
// Data-memory request/ready bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: X/M register, variable-latency load/store with timeout, M/W register and writeback value.
// Stalls the front of the pipeline while a data-memory access is outstanding.
module memory_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   alu_out_x,
  input  logic [15:0]   store_data_x,
  input  logic [3:0]    rt_x,
  input  logic [3:0]    rd_x,
  input  logic          reg_write_x,
  input  logic          mem_read_x,
  input  logic          mem_write_x,
  input  logic          halt_x,
  input  logic          b_m2m,
  memory_stage_if.master mem,
  output logic          stall,
  output logic          mem_err,
  output logic [15:0]   alu_out_xm,
  output logic [3:0]    rt_xm,
  output logic [3:0]    rd_xm,
  output logic          reg_write_xm,
  output logic          mem_write_xm,
  output logic [3:0]    rd_mw,
  output logic          reg_write_mw,
  output logic          halt_mw,
  output logic [15:0]   writeback_data
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] alu_out;
    logic [15:0] store_data;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } xm_t;

  xm_t         xm_q, xm_d;
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [3:0]  rd_mw_q;
  logic        reg_write_mw_q;
  logic        halt_mw_q;
  logic [15:0] data_mw_q, data_mw_d;

  logic access_xm;
  logic req;
  logic timeout;
  logic is_load;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    xm_d            = '0;
    xm_d.alu_out    = alu_out_x;
    xm_d.store_data = store_data_x;
    xm_d.rt         = rt_x;
    xm_d.rd         = rd_x;
    xm_d.reg_write  = reg_write_x;
    xm_d.mem_read   = mem_read_x;
    xm_d.mem_write  = mem_write_x;
    xm_d.halt       = halt_x;
  end

  always_comb begin
    access_xm = xm_q.mem_read | xm_q.mem_write;
    req       = access_xm & (state_q != S_DONE);
    // A store wins when both read and write are flagged.
    is_load   = xm_q.mem_read & ~xm_q.mem_write;
    timeout   = req & (state_q == S_WAIT) & ~mem.mem_ready & (cnt_q == MAX_WAIT_C);
    stall     = req & ~mem.mem_ready & ~timeout;
    data_mw_d = is_load ? (timeout ? 16'h0000 : mem.mem_rdata) : xm_q.alu_out;
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = xm_q.mem_write;
  assign mem.mem_addr  = xm_q.alu_out;
  assign mem.mem_wdata = b_m2m ? data_mw_q : xm_q.store_data;

  // Access sequencer: counts wait cycles and raises the sticky timeout flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req && !mem.mem_ready) begin
            state_q <= S_WAIT;
            cnt_q   <= 8'd1;
          end
        end
        S_WAIT: begin
          if (mem.mem_ready) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else if (timeout) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'd0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xm_q           <= '0;
      rd_mw_q        <= 4'd0;
      reg_write_mw_q <= 1'b0;
      halt_mw_q      <= 1'b0;
      data_mw_q      <= 16'h0000;
    end else begin
      if (!stall) begin
        xm_q <= xm_d;
      end
      // A stalled access sends a bubble downstream; rd and data simply hold.
      if (stall) begin
        reg_write_mw_q <= 1'b0;
        halt_mw_q      <= 1'b0;
      end else begin
        rd_mw_q        <= xm_q.rd;
        reg_write_mw_q <= xm_q.reg_write;
        halt_mw_q      <= xm_q.halt;
        data_mw_q      <= data_mw_d;
      end
    end
  end

  assign mem_err        = err_q;
  assign alu_out_xm     = xm_q.alu_out;
  assign rt_xm          = xm_q.rt;
  assign rd_xm          = xm_q.rd;
  assign reg_write_xm   = xm_q.reg_write;
  assign mem_write_xm   = xm_q.mem_write;
  assign rd_mw          = rd_mw_q;
  assign reg_write_mw   = reg_write_mw_q;
  assign halt_mw        = halt_mw_q;
  assign writeback_data = data_mw_q;

endmodule
